fft_adc_multi: RTL and testbench

FFT_ADC_MULTI -- requirements
Module: fft_adc_multi

---
 rtl/fft_adc_multi.sv | 161 ++++++++++++++++
 tb/tb_fft_adc_multi.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_adc_multi.sv
// fft_adc_multi: frame sequencer for CH ADS8320-class ADCs
// sharing CS/SCL, with a valid/ready output register.
module fft_adc_multi #(
   parameter int CH        = 2,
   parameter int DATA_W    = 16,
   parameter int LEAD_BITS = 6,
   parameter int DIV       = 12,
   parameter int CS_MIN    = 8,
   parameter int PERIOD    = 1024
) (
   input  logic                 iCLK,
   input  logic                 iRESET,
   input  logic                 iEN,
   input  logic                 iCONT,
   input  logic [CH-1:0]        iADC_DATA,
   input  logic                 iREADY,
   input  logic                 iOVR_CLR,
   output logic                 oADC_CS,
   output logic                 oADC_SCL,
   output logic [CH*DATA_W-1:0] oDATA,
   output logic                 oVALID,
   output logic                 oOVR,
   output logic                 oBUSY
);
   localparam int N   = LEAD_BITS + DATA_W;
   localparam int DCW = $clog2(DIV) + 1;
   localparam int ECW = $clog2(N + 1) + 1;
   localparam int GCW = $clog2(CS_MIN) + 1;
   localparam int PCW = $clog2(PERIOD) + 1;

   typedef enum logic [1:0] {IDLE, CONV, GAP} state_t;

   state_t                   state_q, state_d;
   logic                     go, fin, start, tick, gap_end;
   logic [DCW-1:0]           div_q;
   logic [ECW-1:0]           ecnt_q;
   logic [GCW-1:0]           gcnt_q;
   logic [PCW-1:0]           pcnt_q;
   logic                     cs_q, scl_q, rise_q, done_q;
   logic                     cont_q, valid_q, ovr_q;
   logic [CH-1:0][DATA_W-1:0] sh_q;
   logic [CH*DATA_W-1:0]     data_q;

   assign tick    = (div_q == DCW'(DIV - 1));
   assign gap_end = (gcnt_q == GCW'(CS_MIN - 1));
   // First frame after entering continuous mode starts at once.
   assign start   = iEN && (!iCONT || !cont_q ||
                    (pcnt_q == PCW'(PERIOD - 1)));

   // State register.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state; the last GAP cycle doubles as a start decision
   // so back-to-back frames see exactly CS_MIN high cycles.
   always_comb begin
      state_d = state_q;
      go      = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = CONV;
            go      = 1'b1;
         end
         CONV: if (tick && scl_q && ecnt_q == ECW'(N)) begin
            state_d = GAP;
            fin     = 1'b1;
         end
         GAP: if (gap_end) begin
            if (start) begin
               state_d = CONV;
               go      = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // CS/SCL generation, edge, gap and period counters.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         cs_q   <= 1'b1;
         scl_q  <= 1'b1;
         div_q  <= '0;
         ecnt_q <= '0;
         gcnt_q <= '0;
         pcnt_q <= '0;
         rise_q <= 1'b0;
         done_q <= 1'b0;
         cont_q <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         done_q <= fin;
         if (go) begin
            cs_q   <= 1'b0;
            scl_q  <= 1'b1;
            div_q  <= '0;
            ecnt_q <= '0;
            cont_q <= iCONT;
         end else if (fin) begin
            cs_q  <= 1'b1;
            scl_q <= 1'b1;
            div_q <= '0;
         end else if (state_q == CONV) begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
               scl_q <= ~scl_q;
               if (!scl_q) begin
                  ecnt_q <= ecnt_q + 1'b1;
                  rise_q <= 1'b1;
               end
            end
         end
         if (fin)                 gcnt_q <= '0;
         else if (state_q == GAP) gcnt_q <= gcnt_q + 1'b1;
         if (go)
            pcnt_q <= '0;
         else if (pcnt_q != PCW'(PERIOD - 1))
            pcnt_q <= pcnt_q + 1'b1;
      end
   end

   // Shift data bits in MSB-first on the rising-edge cycle.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         sh_q <= '0;
      end else if (rise_q && ecnt_q > ECW'(LEAD_BITS)) begin
         for (int k = 0; k < CH; k++)
            sh_q[k] <= {sh_q[k][DATA_W-2:0], iADC_DATA[k]};
      end
   end

   // Output register, handshake and sticky overrun.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         if (done_q) begin
            data_q  <= sh_q;
            valid_q <= 1'b1;
         end else if (valid_q && iREADY) begin
            valid_q <= 1'b0;
         end
         if (done_q && valid_q && !iREADY) ovr_q <= 1'b1;
         else if (iOVR_CLR)                ovr_q <= 1'b0;
      end
   end

   assign oADC_CS  = cs_q;
   assign oADC_SCL = scl_q;
   assign oDATA    = data_q;
   assign oVALID   = valid_q;
   assign oOVR     = ovr_q;
   assign oBUSY    = (state_q != IDLE);
endmodule

// File: tb/tb_fft_adc_multi.sv
// tb_fft_adc_multi: directed bench with ADC models, a CS/SCL
// monitor and a queue of expected frames.
module tb_fft_adc_multi;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   logic        en0 = 0, cont0 = 0, rdy0 = 0, clr0 = 0;
   logic [1:0]  adc0;
   logic        cs0, scl0, val0, ovr0, busy0;
   logic [31:0] d0;

   logic        en1 = 0, cont1 = 0, rdy1 = 0, clr1 = 0;
   logic [1:0]  adc1;
   logic        cs1, scl1, val1, ovr1, busy1;
   logic [31:0] d1;

   logic        en2 = 0, cont2 = 0, rdy2 = 0, clr2 = 0;
   logic [0:0]  adc2;
   logic        cs2, scl2, val2, ovr2, busy2;
   logic [11:0] d2;

   logic [15:0] w0, w1;
   logic [11:0] w2;
   int          f0 = 0, f1 = 0, f2 = 0;
   logic        sp0 = 1, sp1 = 1, sp2 = 1;
   logic [31:0] exp_q[$];

   int   sel = 0;
   int   cyc = 0, lowcnt = 0, edges = 0, hicnt = 0;
   int   last_low = 0, last_edges = 0, last_high = 0;
   int   fall_t = 0, fall_gap = 0, nfalls = 0;
   int   n0, n1;
   logic mcs, mscl;
   logic cs_p = 1, scl_p = 1;

   always #5 clk = ~clk;

   fft_adc_multi u0 (
      .iCLK(clk), .iRESET(rst), .iEN(en0), .iCONT(cont0),
      .iADC_DATA(adc0), .iREADY(rdy0), .iOVR_CLR(clr0),
      .oADC_CS(cs0), .oADC_SCL(scl0), .oDATA(d0),
      .oVALID(val0), .oOVR(ovr0), .oBUSY(busy0));

   fft_adc_multi #(.PERIOD(100)) u1 (
      .iCLK(clk), .iRESET(rst), .iEN(en1), .iCONT(cont1),
      .iADC_DATA(adc1), .iREADY(rdy1), .iOVR_CLR(clr1),
      .oADC_CS(cs1), .oADC_SCL(scl1), .oDATA(d1),
      .oVALID(val1), .oOVR(ovr1), .oBUSY(busy1));

   fft_adc_multi #(.CH(1), .DATA_W(12), .LEAD_BITS(4),
                   .DIV(2)) u2 (
      .iCLK(clk), .iRESET(rst), .iEN(en2), .iCONT(cont2),
      .iADC_DATA(adc2), .iREADY(rdy2), .iOVR_CLR(clr2),
      .oADC_CS(cs2), .oADC_SCL(scl2), .oDATA(d2),
      .oVALID(val2), .oOVR(ovr2), .oBUSY(busy2));

   // Bit presented after SCL falling edge n; lead bits are junk 1s.
   function automatic logic adc_bit(input logic [15:0] w,
                                    input int n, input int lead,
                                    input int dw);
      int i;
      if (n <= lead || n > lead + dw) return 1'b1;
      i = lead + dw - n;
      return w[i];
   endfunction

   assign adc0 = {adc_bit(w1, f0, 6, 16), adc_bit(w0, f0, 6, 16)};
   assign adc1 = {adc_bit(w1, f1, 6, 16), adc_bit(w0, f1, 6, 16)};
   assign adc2 = adc_bit({4'h0, w2}, f2, 4, 12);

   initial forever begin
      @(posedge clk);
      if (cs0) f0 <= 0; else if (sp0 && !scl0) f0 <= f0 + 1;
      if (cs1) f1 <= 0; else if (sp1 && !scl1) f1 <= f1 + 1;
      if (cs2) f2 <= 0; else if (sp2 && !scl2) f2 <= f2 + 1;
      sp0 <= scl0;
      sp1 <= scl1;
      sp2 <= scl2;
   end

   assign mcs  = (sel == 0) ? cs0  : (sel == 1) ? cs1  : cs2;
   assign mscl = (sel == 0) ? scl0 : (sel == 1) ? scl1 : scl2;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!mcs && cs_p) begin
         last_high = hicnt;
         fall_gap  = cyc - fall_t;
         fall_t    = cyc;
         lowcnt    = 0;
         edges     = 0;
         nfalls++;
      end
      if (mcs && !cs_p) begin
         last_low   = lowcnt;
         last_edges = edges;
         hicnt      = 0;
      end
      if (!mcs) begin
         lowcnt++;
         if (mscl && !scl_p) edges++;
      end else begin
         hicnt++;
      end
      cs_p  = mcs;
      scl_p = mscl;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int id);
      case (id)
         0: return val0;
         1: return busy0;
         2: return cs0;
         3: return busy1;
         4: return val2;
         default: return 1'bx;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int id,
                           input logic lvl, input int lim);
      bit hit = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (sig(id) === lvl) begin
            hit = 1;
            break;
         end
      end
      chk(tag, 64'(hit), 64'd1);
   endtask

   task automatic wait_falls(input string tag, input int n,
                             input int lim);
      bit hit = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (nfalls >= n) begin
            hit = 1;
            break;
         end
      end
      chk(tag, 64'(hit), 64'd1);
   endtask

   task automatic pulse_en0();
      @(negedge clk) en0 = 1;
      @(negedge clk) en0 = 0;
   endtask

   initial begin
      w0 = 16'hA5C3;
      w1 = 16'h1234;
      w2 = 12'hABC;
      repeat (3) @(negedge clk);
      chk("rst_cs", 64'(cs0), 64'd1);
      chk("rst_scl", 64'(scl0), 64'd1);
      chk("rst_valid", 64'(val0), 64'd0);
      chk("rst_ovr", 64'(ovr0), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_data", 64'(d0), 64'd0);
      rst = 0;
      repeat (3) @(negedge clk);
      chk("no_start_wo_en", 64'(busy0), 64'd0);

      exp_q.push_back({w1, w0});
      pulse_en0();
      chk("a_busy", 64'(busy0), 64'd1);
      chk("a_cs_low", 64'(cs0), 64'd0);
      wait_for("a_valid_tmo", 0, 1'b1, 2000);
      chk("a_cs_low_len", 64'(last_low), 64'd540);
      chk("a_edges", 64'(last_edges), 64'd22);
      chk("a_data", 64'(d0), 64'(exp_q.pop_front()));
      repeat (5) @(negedge clk);
      chk("a_hold_valid", 64'(val0), 64'd1);
      chk("a_hold_data", 64'(d0), 64'h1234_A5C3);
      rdy0 = 1;
      @(negedge clk) rdy0 = 0;
      chk("a_valid_clr", 64'(val0), 64'd0);
      wait_for("a_idle_tmo", 1, 1'b0, 100);

      rdy0  = 1;
      cont0 = 1;
      n0    = nfalls;
      en0   = 1;
      wait_falls("b_fall3_tmo", n0 + 3, 5000);
      chk("b_period1", 64'(fall_gap), 64'd1024);
      wait_falls("b_fall4_tmo", n0 + 4, 2000);
      chk("b_period2", 64'(fall_gap), 64'd1024);
      repeat (100) @(negedge clk);
      en0 = 0;
      wait_for("b_idle_tmo", 1, 1'b0, 1000);
      chk("b_ovr", 64'(ovr0), 64'd0);
      n1 = nfalls;
      repeat (1500) @(negedge clk);
      chk("b_no_restart", 64'(nfalls), 64'(n1));
      cont0 = 0;
      rdy0  = 0;

      w0 = 16'h1111;
      w1 = 16'h2222;
      exp_q.push_back({w1, w0});
      pulse_en0();
      wait_for("c_v1_tmo", 0, 1'b1, 2000);
      chk("c_data1", 64'(d0), 64'(exp_q.pop_front()));
      chk("c_ovr_0", 64'(ovr0), 64'd0);
      wait_for("c_idle1_tmo", 1, 1'b0, 100);
      w0 = 16'h3333;
      w1 = 16'h4444;
      exp_q.push_back({w1, w0});
      pulse_en0();
      wait_for("c_idle2_tmo", 1, 1'b0, 2000);
      chk("c_valid2", 64'(val0), 64'd1);
      chk("c_ovr_1", 64'(ovr0), 64'd1);
      chk("c_data2", 64'(d0), 64'(exp_q.pop_front()));
      clr0 = 1;
      @(negedge clk) clr0 = 0;
      chk("c_ovr_clr", 64'(ovr0), 64'd0);

      w0 = 16'h5555;
      w1 = 16'h6666;
      exp_q.push_back({w1, w0});
      pulse_en0();
      wait_for("c_csrise_tmo", 2, 1'b1, 2000);
      rdy0 = 1;
      @(negedge clk) rdy0 = 0;
      chk("c_hs_ovr", 64'(ovr0), 64'd0);
      chk("c_hs_valid", 64'(val0), 64'd1);
      chk("c_hs_data", 64'(d0), 64'(exp_q.pop_front()));

      w0 = 16'hBEEF;
      w1 = 16'h0F0F;
      pulse_en0();
      repeat (300) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("d_cs", 64'(cs0), 64'd1);
      chk("d_scl", 64'(scl0), 64'd1);
      chk("d_valid", 64'(val0), 64'd0);
      chk("d_busy", 64'(busy0), 64'd0);
      chk("d_data", 64'(d0), 64'd0);
      @(negedge clk) rst = 0;
      @(negedge clk);
      exp_q.push_back({w1, w0});
      pulse_en0();
      wait_for("d_valid_tmo", 0, 1'b1, 2000);
      chk("d_frame_data", 64'(d0), 64'(exp_q.pop_front()));
      chk("d_cs_low_len", 64'(last_low), 64'd540);
      chk("d_edges", 64'(last_edges), 64'd22);
      rdy0 = 1;
      @(negedge clk) rdy0 = 0;

      sel   = 1;
      rdy1  = 1;
      cont1 = 1;
      n0    = nfalls;
      en1   = 1;
      wait_falls("e_fall2_tmo", n0 + 2, 2000);
      chk("e_gap1", 64'(last_high), 64'd8);
      chk("e_spacing", 64'(fall_gap), 64'd548);
      wait_falls("e_fall3_tmo", n0 + 3, 2000);
      chk("e_gap2", 64'(last_high), 64'd8);
      en1 = 0;
      wait_for("e_idle_tmo", 3, 1'b0, 1000);

      sel = 2;
      repeat (2) @(negedge clk);
      exp_q.push_back({20'h0, w2});
      @(negedge clk) en2 = 1;
      @(negedge clk) en2 = 0;
      wait_for("f_valid_tmo", 4, 1'b1, 500);
      chk("f_data", 64'(d2), 64'(exp_q.pop_front()));
      chk("f_cs_low_len", 64'(last_low), 64'd66);
      chk("f_edges", 64'(last_edges), 64'd16);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
